// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_core
//   Serial receive stage of the UART peripheral. The asynchronous rx pin is
//   synchronised, 8N1 frames are recovered by sampling each bit in the middle
//   of its bit period, and a good byte is held in a one-deep holding register.
//   The register block reads data_o and acknowledges with rd_ack_i.
//
//   Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames. A ninth
//   bit is then checked for even parity. A mismatch raises parity_err_o and
//   discards the byte. The stop bit is still checked. Without the macro,
//   parity_err_o is tied to 0.
//
// Parameters
//   CLK_FREQ_HZ   system clock frequency
//   BAUD_RATE     line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
//   SYNC_STAGES   synchroniser depth on rx_i (>= 2)
//
// Ports
//   clk_100m_i    in   system clock, rising edge
//   rst_i         in   asynchronous active-high reset
//   rx_i          in   serial line, idle high
//   rd_ack_i      in   1-cycle pulse, consumer has taken data_o
//   clr_err_i     in   1-cycle pulse, clears the sticky error flags
//   data_o        out  holding register, LSB = first data bit on the line
//   data_valid_o  out  holding register full
//   rx_busy_o     out  receiver not idle
//   frame_err_o   out  sticky, stop bit sampled low
//   overrun_o     out  sticky, good byte arrived while holding register full
//   parity_err_o  out  sticky, parity mismatch (0 without UART_RX_PARITY_EN)
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_100m_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       rd_ack_i,
  input  logic       clr_err_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       rx_busy_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Last count of a full bit period, and of the half period used to reach
  // the middle of the start bit.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = 3'd5;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  // Sticky flag update. A new error in the same cycle as a clear keeps the
  // flag set.
  function automatic logic sticky(input logic set, input logic clr, input logic q);
    if (set)
      return 1'b1;
    else if (clr)
      return 1'b0;
    else
      return q;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [2:0]             state_q;
  logic [CNT_W-1:0]       baud_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   par_bad_q;

  logic                   bit_tick;
  logic                   stop_sample;
  logic                   frame_err_set;
  logic                   byte_good;
  logic                   overrun_set;

  logic                   vld_p0;
  logic [7:0]             data_p0;

  // ---- input synchroniser ----------------------------------------------------
  // The flops are preset to 1 so that reset looks like an idle line and does
  // not create a false start bit.
  always_ff @(posedge clk_100m_i or posedge rst_i) begin
    if (rst_i)
      sync_q <= '1;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  assign bit_tick      = (baud_cnt_q == BIT_LAST);
  assign stop_sample   = (state_q == ST_STOP) && bit_tick;
  assign frame_err_set = stop_sample && !rx_s;
  assign byte_good     = stop_sample && rx_s && !par_bad_q;
  assign rx_busy_o     = (state_q != ST_IDLE);

  // ---- frame recovery FSM ----------------------------------------------------
  always_ff @(posedge clk_100m_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q    <= ST_START;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
          end
        end
        ST_START: begin
          // A line that is high again at mid start bit was a glitch.
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            state_q    <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q   <= ST_PARITY;
`else
              state_q   <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            baud_cnt_q <= '0;
            state_q    <= ST_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch the next
          // start edge of back-to-back frames.
          if (bit_tick) begin
            baud_cnt_q <= '0;
            state_q    <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low line (break) must go high before a new frame can start.
          if (rx_s)
            state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100m_i) begin
    if ((state_q == ST_DATA) && bit_tick)
      shift_q <= {rx_s, shift_q[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_set;

  assign parity_err_set = (state_q == ST_PARITY) && bit_tick &&
                          (rx_s != even_parity(shift_q));

  // Remembers a parity failure until the stop bit decides the frame's fate.
  always_ff @(posedge clk_100m_i or posedge rst_i) begin
    if (rst_i)
      par_bad_q <= 1'b0;
    else if ((state_q == ST_IDLE) && !rx_s)
      par_bad_q <= 1'b0;
    else if (parity_err_set)
      par_bad_q <= 1'b1;
  end

  always_ff @(posedge clk_100m_i or posedge rst_i) begin
    if (rst_i)
      parity_err_o <= 1'b0;
    else
      parity_err_o <= sticky(parity_err_set, clr_err_i, parity_err_o);
  end
`else
  assign par_bad_q    = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // ---- stage p0: completed byte ---------------------------------------------
  always_ff @(posedge clk_100m_i or posedge rst_i) begin
    if (rst_i)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= byte_good;
  end

  always_ff @(posedge clk_100m_i) begin
    if (byte_good)
      data_p0 <= shift_q;
  end

  // ---- stage p1: holding register and sticky flags --------------------------
  // An acknowledge in the completion cycle frees the register in time for the
  // new byte, so that case loads without an overrun.
  assign overrun_set = vld_p0 && data_valid_o && !rd_ack_i;

  always_ff @(posedge clk_100m_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
    end else if (vld_p0 && (!data_valid_o || rd_ack_i)) begin
      data_o       <= data_p0;
      data_valid_o <= 1'b1;
    end else if (!vld_p0 && rd_ack_i) begin
      data_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_100m_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= sticky(frame_err_set, clr_err_i, frame_err_o);
      overrun_o   <= sticky(overrun_set, clr_err_i, overrun_o);
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
module tb_uart_rx_core;

  // A fast line rate keeps each frame to a couple of hundred clocks.
  localparam int CLK_HZ   = 100_000_000;
  localparam int BAUD     = 6_250_000;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  logic       clk_100m_i = 1'b0;
  logic       rst_i      = 1'b1;
  logic       rx_i       = 1'b1;
  logic       rd_ack_i   = 1'b0;
  logic       clr_err_i  = 1'b0;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       rx_busy_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  uart_rx_core #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .SYNC_STAGES(2)
  ) dut (
    .clk_100m_i  (clk_100m_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .rd_ack_i    (rd_ack_i),
    .clr_err_i   (clr_err_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .rx_busy_o   (rx_busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk_100m_i = ~clk_100m_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the outputs must read, updated per frame/pulse.
  logic [7:0] exp_data    = 8'h00;
  logic       exp_valid   = 1'b0;
  logic       exp_frame   = 1'b0;
  logic       exp_overrun = 1'b0;
  logic       exp_parity  = 1'b0;
  bit         chk_en      = 1'b0;
  int         busy_mode   = 0;   // 0 don't care, 1 must be busy, 2 must be idle

  logic [7:0] rd;
  bit         r_stop, r_par, r_ack, r_clr;
  int         r_gap;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, just after the active edge.
  always @(posedge clk_100m_i) begin
    #2;
    if (chk_en) begin
      chk("data_o", data_o, exp_data);
      chk("data_valid_o", 8'(data_valid_o), 8'(exp_valid));
      chk("frame_err_o", 8'(frame_err_o), 8'(exp_frame));
      chk("overrun_o", 8'(overrun_o), 8'(exp_overrun));
      chk("parity_err_o", 8'(parity_err_o), 8'(exp_parity));
      if (busy_mode == 1)
        chk("rx_busy_o_high", 8'(rx_busy_o), 8'd1);
      else if (busy_mode == 2)
        chk("rx_busy_o_low", 8'(rx_busy_o), 8'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_100m_i);
  endtask

  // Effect of one whole frame on the visible state, from the receive rules.
  function automatic void model_frame(input logic [7:0] d, input bit stop_ok,
                                      input bit par_ok, input bit ack, input bit clr);
    bit good;
    good = stop_ok && par_ok;
    if (!par_ok)  exp_parity = 1'b1;
    if (!stop_ok) exp_frame  = 1'b1;
    // A clear pulsed at completion comes after the parity/stop decisions.
    if (clr) begin
      exp_frame   = 1'b0;
      exp_parity  = 1'b0;
      exp_overrun = 1'b0;
    end
    if (good) begin
      if (!exp_valid || ack) begin
        exp_data  = d;
        exp_valid = 1'b1;
      end else begin
        exp_overrun = 1'b1;
      end
    end else if (ack) begin
      exp_valid = 1'b0;
    end
  endfunction

  // Drives one frame. With ack/clr set, the pulse is placed in the cycle
  // after rx_busy_o drops at the stop-bit sample.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input bit ack, input bit clr);
    bit pend;
    bit seen;
    busy_mode = 0;
    rx_i = 1'b0;
    wait_clks(BIT_CLKS);
    busy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      wait_clks(BIT_CLKS);
    end
    chk_en    = 1'b0;
    busy_mode = 0;
`ifdef UART_RX_PARITY_EN
    rx_i = (^d) ^ !par_ok;
    wait_clks(BIT_CLKS);
`endif
    rx_i = stop_ok;
    pend = ack || clr;
    seen = 1'b0;
    for (int i = 0; i < BIT_CLKS; i++) begin
      @(negedge clk_100m_i);
      if (rd_ack_i || clr_err_i) begin
        rd_ack_i  = 1'b0;
        clr_err_i = 1'b0;
      end else if (pend && !rx_busy_o) begin
        rd_ack_i  = ack;
        clr_err_i = clr;
        pend      = 1'b0;
        seen      = 1'b1;
      end
    end
    if (rd_ack_i || clr_err_i) begin
      @(negedge clk_100m_i);
      rd_ack_i  = 1'b0;
      clr_err_i = 1'b0;
    end
    if (ack || clr)
      chk("completion_seen", 8'(seen), 8'd1);
    model_frame(d, stop_ok, par_ok, ack, clr);
    chk_en = 1'b1;
  endtask

  task automatic idle(input int bits);
    rx_i      = 1'b1;
    busy_mode = 0;
    wait_clks(4);
    busy_mode = 2;
    wait_clks(bits * BIT_CLKS - 4);
  endtask

  task automatic hold_low(input int bits);
    rx_i      = 1'b0;
    busy_mode = 1;
    wait_clks(bits * BIT_CLKS);
  endtask

  task automatic glitch(input int n);
    busy_mode = 0;
    rx_i = 1'b0;
    wait_clks(n);
    rx_i = 1'b1;
    wait_clks(BIT_CLKS);
    idle(1);
  endtask

  task automatic pulse_ack();
    rd_ack_i  = 1'b1;
    exp_valid = 1'b0;
    wait_clks(1);
    rd_ack_i  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err_i   = 1'b1;
    exp_frame   = 1'b0;
    exp_overrun = 1'b0;
    exp_parity  = 1'b0;
    wait_clks(1);
    clr_err_i   = 1'b0;
  endtask

  initial begin
    // Reset state
    wait_clks(20);
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", 8'(data_valid_o), 8'd0);
    chk("rst_busy", 8'(rx_busy_o), 8'd0);
    chk("rst_frame", 8'(frame_err_o), 8'd0);
    chk("rst_overrun", 8'(overrun_o), 8'd0);
    chk("rst_parity", 8'(parity_err_o), 8'd0);
    rst_i  = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Single frame
    send_frame(8'hAB, 1, 1, 0, 0);
    idle(2);
    chk("t1_data", data_o, 8'hAB);
    chk("t1_valid", 8'(data_valid_o), 8'd1);
    chk("t1_frame", 8'(frame_err_o), 8'd0);
    chk("t1_overrun", 8'(overrun_o), 8'd0);
    chk("t1_busy", 8'(rx_busy_o), 8'd0);
    pulse_ack();

    // Start-bit glitch
    glitch(4);
    chk("t2_valid", 8'(data_valid_o), 8'd0);
    chk("t2_frame", 8'(frame_err_o), 8'd0);
    chk("t2_busy", 8'(rx_busy_o), 8'd0);

    // Framing error, held-low line, recovery
    send_frame(8'h55, 0, 1, 0, 0);
    hold_low(2);
    idle(2);
    chk("t3_frame", 8'(frame_err_o), 8'd1);
    chk("t3_valid", 8'(data_valid_o), 8'd0);
    send_frame(8'h3C, 1, 1, 0, 0);
    idle(2);
    chk("t3_data", data_o, 8'h3C);
    pulse_ack();
    pulse_clr();
    idle(1);
    chk("t3_clr", 8'(frame_err_o), 8'd0);

    // Overrun, with a clear landing on the overrun cycle
    send_frame(8'h11, 1, 1, 0, 0);
    idle(1);
    send_frame(8'h22, 1, 1, 0, 1);
    idle(2);
    chk("t4_data", data_o, 8'h11);
    chk("t4_overrun", 8'(overrun_o), 8'd1);
    pulse_ack();
    send_frame(8'h33, 1, 1, 0, 0);
    idle(2);
    chk("t4_data2", data_o, 8'h33);
    pulse_ack();
    pulse_clr();

    // Back-to-back frames, acknowledge on the completion cycle
    send_frame(8'h5A, 1, 1, 0, 0);
    send_frame(8'hA5, 1, 1, 1, 0);
    idle(2);
    chk("t5_data", data_o, 8'hA5);
    chk("t5_valid", 8'(data_valid_o), 8'd1);
    chk("t5_overrun", 8'(overrun_o), 8'd0);

    // Reset in the middle of a frame
    busy_mode = 0;
    rx_i = 1'b0;
    wait_clks(BIT_CLKS);
    busy_mode = 1;
    rx_i = 1'b1;
    wait_clks(BIT_CLKS);
    rx_i = 1'b0;
    wait_clks(BIT_CLKS);
    rst_i       = 1'b1;
    rx_i        = 1'b1;
    busy_mode   = 2;
    exp_data    = 8'h00;
    exp_valid   = 1'b0;
    exp_frame   = 1'b0;
    exp_overrun = 1'b0;
    exp_parity  = 1'b0;
    wait_clks(3);
    chk("t5_rst_data", data_o, 8'h00);
    chk("t5_rst_valid", 8'(data_valid_o), 8'd0);
    chk("t5_rst_busy", 8'(rx_busy_o), 8'd0);
    rst_i = 1'b0;
    idle(3);
    send_frame(8'h7E, 1, 1, 0, 0);
    idle(2);
    chk("t5_data2", data_o, 8'h7E);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    // Even parity
    send_frame(8'hAB, 1, 1, 0, 0);
    idle(2);
    chk("t6_data", data_o, 8'hAB);
    chk("t6_parity_ok", 8'(parity_err_o), 8'd0);
    pulse_ack();
    send_frame(8'h5E, 1, 0, 0, 0);
    idle(2);
    chk("t6_data_kept", data_o, 8'hAB);
    chk("t6_valid", 8'(data_valid_o), 8'd0);
    chk("t6_parity_err", 8'(parity_err_o), 8'd1);
    pulse_clr();
`endif

    // Randomised traffic
    for (int n = 0; n < 50; n++) begin
      rd     = 8'($urandom_range(0, 255));
      r_stop = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      r_par  = ($urandom_range(0, 5) != 0);
`else
      r_par  = 1'b1;
`endif
      r_ack  = r_stop && ($urandom_range(0, 3) == 0);
      r_clr  = r_stop && !r_ack && ($urandom_range(0, 5) == 0);
      send_frame(rd, r_stop, r_par, r_ack, r_clr);
      if (!r_stop) begin
        hold_low($urandom_range(0, 2));
        r_gap = 1 + $urandom_range(0, 1);
      end else begin
        r_gap = $urandom_range(0, 3);
      end
      if (r_gap > 0) begin
        idle(r_gap);
        if ($urandom_range(0, 1) == 0) pulse_ack();
        if ($urandom_range(0, 4) == 0) pulse_clr();
        if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, BIT_CLKS / 2 - 2));
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
